// File: rtl/fp32_unpacker_if.sv
// Operand/result bundle for fp32_unpacker.
//   valid_i, data_i        : binary32 operand and its strobe (producer -> unpacker)
//   valid_o, result_o      : Q2.30 result and its strobe (unpacker -> consumer)
//   sign_o, is_special_o,
//   overflow_o, invalid_o  : status flags travelling with result_o
interface fp32_unpacker_if;
   logic        valid_i;
   logic [31:0] data_i;
   logic        valid_o;
   logic [31:0] result_o;
   logic        sign_o;
   logic        is_special_o;
   logic        overflow_o;
   logic        invalid_o;

   // Producer/consumer side (drives operands, observes results)
   modport master (
      output valid_i, data_i,
      input  valid_o, result_o, sign_o, is_special_o, overflow_o, invalid_o
   );

   // Unpacker side
   modport slave (
      input  valid_i, data_i,
      output valid_o, result_o, sign_o, is_special_o, overflow_o, invalid_o
   );
endinterface

// File: rtl/fp32_unpacker.sv
// IEEE-754 binary32 to Q2.30 fixed-point converter, one register stage.
//   clk, rst      : rising-edge clock, synchronous active-high reset
//   bus (slave)   : valid_i/data_i operand in; valid_o/result_o plus
//                   sign_o, is_special_o, overflow_o, invalid_o out
// Result truncates toward zero, saturates on |x| >= 2.0 (exact -2.0 is
// representable), and forces 0 with invalid_o on NaN.
module fp32_unpacker (
   input  logic             clk,
   input  logic             rst,
   fp32_unpacker_if.slave   bus
);

   localparam int unsigned DATA_W = 32;
   localparam int unsigned EXP_W  = 8;
   localparam int unsigned FRAC_W = 23;
   localparam int unsigned SH_W   = 5;

   localparam logic [DATA_W-1:0] POS_SAT  = 32'h7FFF_FFFF;
   localparam logic [DATA_W-1:0] NEG_SAT  = 32'h8000_0000;
   localparam logic [DATA_W-1:0] POS_ONE  = 32'h3F80_0000;
   localparam logic [DATA_W-1:0] NEG_ONE  = 32'hBF80_0000;
   localparam logic [DATA_W-1:0] NEG_TWO  = 32'hC000_0000;

   logic              sign_c;
   logic [EXP_W-1:0]  exp_c;
   logic [FRAC_W-1:0] frac_c;
   logic [DATA_W-1:0] sig_c;
   logic [SH_W-1:0]   rsh_c;
   logic [DATA_W-1:0] mag_c;
   logic              is_nan_c;
   logic              is_big_c;
   logic              is_neg2_c;
   logic [DATA_W-1:0] conv_c;

   logic              valid_q,   valid_d;
   logic [DATA_W-1:0] result_q,  result_d;
   logic              sign_q,    sign_d;
   logic              special_q, special_d;
   logic              ovf_q,     ovf_d;
   logic              inv_q,     inv_d;

   // Field decode and barrel shift of the significand
   always_comb begin
      sign_c = bus.data_i[31];
      exp_c  = bus.data_i[30:23];
      frac_c = bus.data_i[22:0];
      // Hidden bit only for normals, so denormals/zero collapse to 0 below
      sig_c  = {8'd0, (exp_c != 8'd0), frac_c};
      // 120 - E for E in 97..119; 120 mod 32 = 24, so low 5 bits suffice
      rsh_c  = SH_W'(5'd24 - exp_c[4:0]);
      mag_c  = '0;
      if (exp_c >= 8'd120 && exp_c <= 8'd127) begin
         // E - 120 is exactly exp[2:0] over this range
         mag_c = sig_c << exp_c[2:0];
      end else if (exp_c >= 8'd97 && exp_c < 8'd120) begin
         mag_c = sig_c >> rsh_c;
      end

      is_nan_c  = (exp_c == 8'hFF) && (frac_c != '0);
      is_big_c  = (exp_c >= 8'd128);
      is_neg2_c = (bus.data_i == NEG_TWO);

      if (is_nan_c) begin
         conv_c = '0;
      end else if (is_neg2_c) begin
         conv_c = NEG_SAT;
      end else if (is_big_c) begin
         conv_c = sign_c ? NEG_SAT : POS_SAT;
      end else begin
         conv_c = sign_c ? (~mag_c + 32'd1) : mag_c;
      end
   end

   // Output register next-state: load on valid_i, otherwise hold
   always_comb begin
      valid_d   = bus.valid_i;
      result_d  = result_q;
      sign_d    = sign_q;
      special_d = special_q;
      ovf_d     = ovf_q;
      inv_d     = inv_q;
      if (bus.valid_i) begin
         result_d  = conv_c;
         sign_d    = sign_c;
         special_d = (bus.data_i == POS_ONE) || (bus.data_i == NEG_ONE);
         ovf_d     = is_big_c && !is_nan_c && !is_neg2_c;
         inv_d     = is_nan_c;
      end
   end

   // Output register, reset wins over a concurrent operand
   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q   <= 1'b0;
         result_q  <= '0;
         sign_q    <= 1'b0;
         special_q <= 1'b0;
         ovf_q     <= 1'b0;
         inv_q     <= 1'b0;
      end else begin
         valid_q   <= valid_d;
         result_q  <= result_d;
         sign_q    <= sign_d;
         special_q <= special_d;
         ovf_q     <= ovf_d;
         inv_q     <= inv_d;
      end
   end

   assign bus.valid_o      = valid_q;
   assign bus.result_o     = result_q;
   assign bus.sign_o       = sign_q;
   assign bus.is_special_o = special_q;
   assign bus.overflow_o   = ovf_q;
   assign bus.invalid_o    = inv_q;

endmodule

// File: tb/tb_fp32_unpacker.sv
// Self-checking bench for fp32_unpacker: directed operands with
// hand-computed results, plus an arithmetic reference model compared
// against the DUT on every falling edge.
module tb_fp32_unpacker;

   typedef struct packed {
      logic [31:0] r;
      logic        s;
      logic        sp;
      logic        ov;
      logic        inv;
   } res_t;

   typedef struct packed {
      logic [31:0] d;
      res_t        lit;
   } vec_t;

   logic clk;
   logic rst;
   fp32_unpacker_if bus ();

   fp32_unpacker dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   // Reference: value = sig * 2^(E-150), scaled by 2^30, truncated, then clipped
   function automatic res_t model(input logic [31:0] d);
      res_t   o;
      int     e;
      longint sig;
      longint mag;
      longint v;
      bit     huge;
      e    = int'(d[30:23]);
      o    = '0;
      o.s  = d[31];
      o.sp = (d == 32'h3F80_0000) || (d == 32'hBF80_0000);
      if (e == 255 && d[22:0] != 23'd0) begin
         o.inv = 1'b1;
         o.r   = 32'd0;
         return o;
      end
      sig  = (e == 0) ? 64'sd0 : longint'({1'b1, d[22:0]});
      huge = (e >= 160);
      mag  = 0;
      if (!huge) begin
         if (e >= 120) mag = sig << (e - 120);
         else if (120 - e < 64) mag = sig >> (120 - e);
      end
      v = d[31] ? -mag : mag;
      if (!d[31] && (huge || v > 64'sh7FFF_FFFF)) begin
         o.r = 32'h7FFF_FFFF; o.ov = 1'b1;
      end else if (d[31] && (huge || v < -64'sh8000_0000)) begin
         o.r = 32'h8000_0000; o.ov = 1'b1;
      end else begin
         o.r = v[31:0];
      end
      return o;
   endfunction

   // Expected output registers, advanced by the model on each rising edge
   logic exp_valid;
   res_t exp_res;
   logic rst_prev;
   vec_t lit_q[$];

   always @(posedge clk) begin
      rst_prev <= rst;
      if (rst) begin
         exp_valid <= 1'b0;
         exp_res   <= '0;
      end else if (bus.valid_i) begin
         exp_valid <= 1'b1;
         exp_res   <= model(bus.data_i);
      end else begin
         exp_valid <= 1'b0;
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
      checks++;
      if (act !== expv) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h", name, act, expv);
      end
   endtask

   bit pinned = 0;
   res_t pm;
   vec_t lv;

   // Single compare process
   always @(negedge clk) begin
      if (!pinned) begin
         pinned = 1;
         pm = model(32'h3F47AE14); chk("model_0p78", pm.r, 32'h31EB8500);
         pm = model(32'h350637BD); chk("model_5e-7", pm.r, 32'h00000218);
         pm = model(32'hC0000000); chk("model_neg2_ov", 32'(pm.ov), 32'd0);
         pm = model(32'h40000000); chk("model_pos2", pm.r, 32'h7FFFFFFF);
      end
      chk("valid_o", 32'(bus.valid_o), 32'(exp_valid));
      chk("result_o", bus.result_o, exp_res.r);
      chk("sign_o", 32'(bus.sign_o), 32'(exp_res.s));
      chk("is_special_o", 32'(bus.is_special_o), 32'(exp_res.sp));
      chk("overflow_o", 32'(bus.overflow_o), 32'(exp_res.ov));
      chk("invalid_o", 32'(bus.invalid_o), 32'(exp_res.inv));
      if (rst_prev === 1'b1) begin
         chk("reset_zero", {26'd0, bus.valid_o, bus.sign_o, bus.is_special_o,
                            bus.overflow_o, bus.invalid_o, |bus.result_o}, 32'd0);
      end
      if (exp_valid === 1'b1) begin
         if (lit_q.size() == 0) begin
            chk("literal_queue_empty", 32'd0, 32'd1);
         end else begin
            lv = lit_q.pop_front();
            chk($sformatf("lit_res_%h", lv.d), bus.result_o, lv.lit.r);
            chk($sformatf("lit_flags_%h", lv.d),
                {28'd0, bus.sign_o, bus.is_special_o, bus.overflow_o, bus.invalid_o},
                {28'd0, lv.lit.s, lv.lit.sp, lv.lit.ov, lv.lit.inv});
         end
      end
   end

   task automatic drive(input vec_t v);
      @(posedge clk); #1;
      bus.valid_i = 1'b1;
      bus.data_i  = v.d;
      lit_q.push_back(v);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk); #1;
         bus.valid_i = 1'b0;
         bus.data_i  = 32'hDEAD_BEEF;
      end
   endtask

   // {data, {result, sign, special, overflow, invalid}}
   vec_t vecs [19] = '{
      '{32'h3F800000, '{32'h40000000, 1'b0, 1'b1, 1'b0, 1'b0}},
      '{32'hBF800000, '{32'hC0000000, 1'b1, 1'b1, 1'b0, 1'b0}},
      '{32'h30800000, '{32'h00000001, 1'b0, 1'b0, 1'b0, 1'b0}},
      '{32'h350637BD, '{32'h00000218, 1'b0, 1'b0, 1'b0, 1'b0}},
      '{32'h00000000, '{32'h00000000, 1'b0, 1'b0, 1'b0, 1'b0}},
      '{32'h80000000, '{32'h00000000, 1'b1, 1'b0, 1'b0, 1'b0}},
      '{32'h30000000, '{32'h00000000, 1'b0, 1'b0, 1'b0, 1'b0}},
      '{32'h3F000000, '{32'h20000000, 1'b0, 1'b0, 1'b0, 1'b0}},
      '{32'h3F47AE14, '{32'h31EB8500, 1'b0, 1'b0, 1'b0, 1'b0}},
      '{32'h3F1B74EE, '{32'h26DD3B80, 1'b0, 1'b0, 1'b0, 1'b0}},
      '{32'hBF000000, '{32'hE0000000, 1'b1, 1'b0, 1'b0, 1'b0}},
      '{32'h40000000, '{32'h7FFFFFFF, 1'b0, 1'b0, 1'b1, 1'b0}},
      '{32'hC0000000, '{32'h80000000, 1'b1, 1'b0, 1'b0, 1'b0}},
      '{32'h7F800000, '{32'h7FFFFFFF, 1'b0, 1'b0, 1'b1, 1'b0}},
      '{32'hFF800000, '{32'h80000000, 1'b1, 1'b0, 1'b1, 1'b0}},
      '{32'h7FC00000, '{32'h00000000, 1'b0, 1'b0, 1'b0, 1'b1}},
      '{32'hC0000001, '{32'h80000000, 1'b1, 1'b0, 1'b1, 1'b0}},
      '{32'h3FFFFFFF, '{32'h7FFFFF80, 1'b0, 1'b0, 1'b0, 1'b0}},
      '{32'h30800001, '{32'h00000001, 1'b0, 1'b0, 1'b0, 1'b0}}
   };

   initial begin
      rst         = 1'b1;
      bus.valid_i = 1'b0;
      bus.data_i  = 32'd0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;

      // Back-to-back stream covering all directed vectors
      foreach (vecs[i]) drive(vecs[i]);
      // Dropped valid: outputs hold, valid_o falls
      idle(3);

      // Four consecutive operands, then a gap
      drive(vecs[7]);
      drive(vecs[10]);
      drive(vecs[8]);
      drive(vecs[13]);
      idle(2);

      // Reset mid-stream with an operand present: operand is discarded
      drive(vecs[9]);
      drive(vecs[11]);
      @(posedge clk); #1;
      rst         = 1'b1;
      bus.valid_i = 1'b1;
      bus.data_i  = 32'h3F800000;
      @(posedge clk); #1;
      rst         = 1'b0;
      bus.valid_i = 1'b0;
      drive(vecs[1]);
      idle(3);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   // Watchdog
   initial begin
      #100000;
      $display("FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/fp32_unpacker.md
# fp32_unpacker

Converts an IEEE-754 single-precision value into a 32-bit signed fixed-point word with 30 fractional bits (Q2.30, 1.0 = 0x40000000). It is the input stage of the CORDIC datapath: host-side floats enter here and leave as fixed-point angles or operands. It also flags sign, exact ±1.0, overflow and NaN for downstream control. The block is registered with one-cycle latency.

## Interface
- No parameters. Formats are fixed: fp32 in, Q2.30 out.
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- valid_i  input  1  data_i is valid this cycle.
- data_i  input  32  IEEE-754 binary32 operand: sign[31], exp[30:23], frac[22:0].
- valid_o  output  1  result and flags are valid.
- result_o  output  32  two's-complement Q2.30 result.
- sign_o  output  1  raw sign bit of the captured input.
- is_special_o  output  1  input is exactly +1.0 (0x3F800000) or −1.0 (0xBF800000).
- overflow_o  output  1  |input| ≥ 2.0 (except exact −2.0) or ±Inf; result is saturated.
- invalid_o  output  1  input is NaN.

## Operation
- Let E be the exponent field and S = {1, frac}, 24 bits.
- Normal numbers: magnitude = S·2^(E−120).
  - E ≥ 120: shift S left by E−120.
  - E < 120: shift S right by 120−E.
  - Truncate toward zero; discarded bits are dropped with no rounding.
- Underflow: E ≤ 96 (|x| < 2^-30) gives magnitude 0. E = 97 with frac = 0 (2^-30) gives 1.
- Zero and denormals (E = 0) give 0. −0 gives 0x00000000, with sign_o = 1.
- Sign: negative inputs take the two's complement of the magnitude.
- Range:
  - E ≥ 128 (|x| ≥ 2.0) sets overflow_o and saturates the result: positive to 0x7FFFFFFF, negative to 0x80000000.
  - Exact −2.0 (0xC0000000) gives 0x80000000 with overflow_o = 0.
- Inf (E = 255, frac = 0): saturates by sign and sets overflow_o.
- NaN (E = 255, frac ≠ 0): result 0, invalid_o = 1, overflow_o = 0.
- is_special_o depends only on the exact bit patterns above and is independent of the other flags.
- Implementation: combinational decode plus a barrel shifter of at least 0–23 right and 0–7 left, feeding one output register stage.

## Timing
- Latency is 1 cycle. On a rising edge with valid_i = 1, result_o and all flags load the conversion of data_i, and valid_o goes to 1 on the next cycle.
- valid_i = 0: valid_o goes to 0, and result_o and the flags hold their previous values.
- No backpressure. A new operand may be accepted every cycle, for full throughput.
- Reset, checked on each rising edge: rst = 1 clears valid_o, result_o, sign_o, is_special_o, overflow_o and invalid_o to 0 on that edge.
  - Reset has priority over valid_i.
  - An operand presented in a reset cycle is discarded.
- Outputs are purely registered: no combinational path from inputs to outputs.

## Test plan
- Each line below applies data_i with valid_i = 1 and checks result_o one cycle later.
- Exact ±1: 0x3F800000 → 0x40000000, is_special_o = 1, sign_o = 0. 0xBF800000 → 0xC0000000, is_special_o = 1, sign_o = 1.
- Small values:
  - 0x30800000 (2^-30) → 0x00000001.
  - 0x350637BD (5e-7) → 0x00000218 (truncated).
  - 0x00000000 → 0x00000000.
  - 0x30000000 (2^-31) → 0x00000000.
- Mid range:
  - 0x3F000000 (0.5) → 0x20000000.
  - 0x3F47AE14 (0.78) → 0x31EB8500.
  - 0x3F1B74EE → 0x26DD3B80.
  - 0xBF000000 → 0xE0000000.
- Range limits:
  - 0x40000000 (2.0) → 0x7FFFFFFF, overflow_o = 1.
  - 0xC0000000 (−2.0) → 0x80000000, overflow_o = 0.
  - 0x7F800000 (+Inf) → 0x7FFFFFFF, overflow_o = 1.
  - 0x7FC00000 (NaN) → 0x00000000, invalid_o = 1.
- Control:
  - Back-to-back valid_i for 4 cycles gives 4 consecutive results with valid_o high.
  - Dropping valid_i holds result_o and pulls valid_o low.
  - Asserting rst mid-stream zeroes all outputs on the next edge, even with valid_i = 1.
